ncc_window_loader: RTL and testbench
====================================

// Module: ncc_window_loader
// PURPOSE
//  Byte-stream loader for the NCC search window, sitting directly upstream of the ncc correlator.
//  Accepts window pixels from the PCI byte path in raster order and stores them in WIN_ROWS row banks.
//  Once the full window is held, the correlator reads one column per request, all rows in parallel.
//  Single-buffered: a new load starts only after the consumer releases the window, or on an explicit abort-restart.
// PARAMETERS
//  WIN_ROWS  16  window height in pixels; one storage bank per row
//  WIN_COLS  40  window width in pixels; WIN_ROWS*WIN_COLS = 640 = windowSize
// PORTS
//  clk          in   1                  single clock, rising edge
//  rst          in   1                  asynchronous, active-high reset
//  start        in   1                  begin (or restart) a window load
//  pix_in       in   8                  pixel byte from PCI path
//  pix_valid    in   1                  pix_in valid this cycle
//  pix_ready    out  1                  loader accepts pix_in this cycle
//  win_ready    out  1                  complete window held, reads allowed
//  release_win  in   1                  consumer done with window
//  rd_en        in   1                  column read request
//  rd_col       in   $clog2(WIN_COLS)   column to read
//  rd_valid     out  1                  rd_data valid (1 cycle after accepted rd_en)
//  rd_data      out  8*WIN_ROWS         column pixels; rd_data[8*r +: 8] = row r
//  pix_count    out  $clog2(WIN_ROWS*WIN_COLS+1)  pixels accepted in current load
//  drop_err     out  1                  sticky: pix_valid seen while pix_ready=0
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; pix_ready=0, win_ready=0, rd_valid=0, rd_data=0,
//   pix_count=0, drop_err=0, row/col counters=0. Storage contents undefined; never read before loaded.
//  FSM states IDLE, LOAD, FULL:
//   IDLE: pix_ready=0. start=1 -> LOAD next cycle; counters, pix_count, drop_err cleared.
//   LOAD: pix_ready=1. Each cycle with pix_valid=1 writes pix_in to bank[row][col];
//    col increments; at col=WIN_COLS-1 col wraps to 0 and row increments; pix_count increments.
//    Write of the last pixel (row=WIN_ROWS-1, col=WIN_COLS-1) -> FULL next cycle;
//    pix_ready=0 from that next cycle on. start=1 in LOAD: restart — counters, pix_count cleared,
//    stay in LOAD, and any pixel presented that same cycle is dropped (not written, not counted).
//   FULL: win_ready=1, pix_ready=0. release_win=1 -> IDLE. start=1 -> LOAD (counters cleared);
//    start takes priority over release_win in the same cycle.
//  pix_valid=1 while pix_ready=0 (IDLE, FULL, or restart cycle) sets drop_err; it stays set until
//   the next start. The pixel is discarded.
//  Reads: accepted only when state=FULL, rd_en=1, and rd_col<WIN_COLS. Next cycle: rd_valid=1 and
//   rd_data holds column rd_col. Rejected requests give rd_valid=0 next cycle; rd_data holds its
//   previous value. Back-to-back reads: one column per cycle, fully pipelined.
//  A read accepted in the same cycle as release_win still returns valid data next cycle.
//  pix_count saturates at WIN_ROWS*WIN_COLS and holds in FULL until start.
//  All counters are unsigned; no wrap beyond the window bounds is possible by construction.
// TESTING
//  Reset mid-LOAD (after 100 pixels): all outputs 0 the same cycle; state IDLE; pix_count=0.
//  start, stream 640 bytes value (r*40+c)&8'hFF with pix_valid held high: win_ready=1 exactly one
//   cycle after byte 640; pix_count=640; rd_col=5 -> rd_data[8*r+:8]=(r*40+5)&8'hFF for all r.
//  Gapped stream (pix_valid toggled every other cycle): same contents as gapless; drop_err=0.
//  Extra byte after the 640th, plus a pixel in IDLE: drop_err=1; window contents unchanged; next start clears it.
//  Mid-load restart at pixel 300, then 640 bytes of 8'hA5: every column reads all-8'hA5; pix_count=640.
//  Reads: rd_col=39 -> valid; rd_col=40 -> rd_valid=0; rd_en in LOAD -> rd_valid=0;
//   start+release_win in FULL -> LOAD.

Source files
------------

// File: rtl/ncc_window_loader.sv
// Raster-order byte loader for the NCC search window: one storage bank per window row,
// column reads return all rows in parallel once the window is complete.
module ncc_window_loader #(
  parameter int WIN_ROWS = 16,
  parameter int WIN_COLS = 40
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [7:0]                               pix_in,
  input  logic                                     pix_valid,
  output logic                                     pix_ready,
  output logic                                     win_ready,
  input  logic                                     release_win,
  input  logic                                     rd_en,
  input  logic [$clog2(WIN_COLS)-1:0]              rd_col,
  output logic                                     rd_valid,
  output logic [8*WIN_ROWS-1:0]                    rd_data,
  output logic [$clog2(WIN_ROWS*WIN_COLS+1)-1:0]   pix_count,
  output logic                                     drop_err
);

  localparam int NPIX  = WIN_ROWS * WIN_COLS;
  localparam int COL_W = $clog2(WIN_COLS);
  localparam int ROW_W = $clog2(WIN_ROWS);
  localparam int CNT_W = $clog2(NPIX + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             wr_en;
  logic             rd_accept;
  logic             drop_now;
  logic             last_pix;

  // A start in LOAD is a restart: the pixel on that cycle is neither stored nor counted.
  assign wr_en     = (state == LOAD) && pix_valid && !start;
  assign drop_now  = pix_valid && ((state != LOAD) || start);
  assign rd_accept = (state == FULL) && rd_en &&
                     ({1'b0, rd_col} < (COL_W + 1)'(WIN_COLS));
  assign last_pix  = (row == ROW_W'(WIN_ROWS - 1)) && (col == COL_W'(WIN_COLS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pix_ready <= 1'b0;
      win_ready <= 1'b0;
      rd_valid  <= 1'b0;
      row       <= '0;
      col       <= '0;
      pix_count <= '0;
      drop_err  <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (start) begin
        // start wins over release_win and over any pixel in flight
        state     <= LOAD;
        pix_ready <= 1'b1;
        win_ready <= 1'b0;
        row       <= '0;
        col       <= '0;
        pix_count <= '0;
        drop_err  <= drop_now;
      end else begin
        drop_err <= drop_err | drop_now;
        case (state)
          IDLE: begin
            pix_ready <= 1'b0;
            win_ready <= 1'b0;
          end
          LOAD: begin
            if (wr_en) begin
              pix_count <= pix_count + CNT_W'(1);
              if (last_pix) begin
                state     <= FULL;
                pix_ready <= 1'b0;
                win_ready <= 1'b1;
              end else if (col == COL_W'(WIN_COLS - 1)) begin
                col <= '0;
                row <= row + ROW_W'(1);
              end else begin
                col <= col + COL_W'(1);
              end
            end
          end
          FULL: begin
            if (release_win) begin
              state     <= IDLE;
              win_ready <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            pix_ready <= 1'b0;
            win_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < WIN_ROWS; gi++) begin : g_bank
      logic [7:0] bank [WIN_COLS];
      logic [7:0] word;

      always_ff @(posedge clk) begin
        if (wr_en && (row == ROW_W'(gi)))
          bank[col] <= pix_in;
      end

      // Registered read; a rejected request leaves the previous column on the output.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          word <= '0;
        else if (rd_accept)
          word <= bank[rd_col];
      end

      assign rd_data[8*gi +: 8] = word;
    end
  endgenerate

endmodule

// File: tb/tb_ncc_window_loader.sv
// Scoreboard bench for ncc_window_loader: stimulus queues expected columns,
// a negedge monitor pops and compares whenever rd_valid is presented.
module tb_ncc_window_loader;
  localparam int R = 16;
  localparam int C = 40;
  localparam int N = R * C;

  logic         clk = 1'b0;
  logic         rst, start, pix_valid, release_win, rd_en;
  logic [7:0]   pix_in;
  logic [5:0]   rd_col;
  logic         pix_ready, win_ready, rd_valid, drop_err;
  logic [127:0] rd_data;
  logic [9:0]   pix_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]   model [R][C];
  logic [127:0] exp_q [$];

  ncc_window_loader #(.WIN_ROWS(R), .WIN_COLS(C)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .win_ready(win_ready), .release_win(release_win),
    .rd_en(rd_en), .rd_col(rd_col), .rd_valid(rd_valid), .rd_data(rd_data),
    .pix_count(pix_count), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] col_of(input int c);
    logic [127:0] v;
    v = '0;
    for (int r = 0; r < R; r++) v[8*r +: 8] = model[r][c];
    return v;
  endfunction

  // Monitor: every presented read result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: got rd_valid=1 expected no pending read");
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        check("rd_data", rd_data, e);
        $display("read data=%h expected=%h", rd_data, e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic stream(input int n, input bit a5, input bit gapped, input bit expect_full);
    for (int i = 0; i < n; i++) begin
      if (gapped) begin
        pix_valid = 1'b0;
        cyc(1);
      end
      pix_in    = a5 ? 8'hA5 : 8'(i);
      pix_valid = 1'b1;
      model[i / C][i % C] = pix_in;
      if (expect_full && i == n - 1) check("win_ready_before_last", win_ready, 0);
      cyc(1);
    end
    pix_valid = 1'b0;
    if (expect_full) begin
      check("win_ready_after_last", win_ready, 1);
      check("pix_count_full", pix_count, N);
      check("pix_ready_full", pix_ready, 0);
    end
  endtask

  task automatic read_cols(input int first, input int count);
    rd_en = 1'b1;
    for (int k = 0; k < count; k++) begin
      rd_col = 6'(first + k);
      exp_q.push_back(col_of(first + k));
      cyc(1);
    end
    rd_en = 1'b0;
  endtask

  task automatic read_reject(input int c, input string name);
    rd_en  = 1'b1;
    rd_col = 6'(c);
    cyc(1);
    rd_en = 1'b0;
    check(name, rd_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
    release_win = 1'b0; rd_en = 1'b0; rd_col = '0;
    cyc(2);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_win_ready", win_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_pix_count", pix_count, 0);
    check("rst_drop_err", drop_err, 0);
    rst = 1'b0;
    cyc(1);
    check("idle_pix_ready", pix_ready, 0);

    // Gapless load of the raster pattern
    do_start();
    check("load_pix_ready", pix_ready, 1);
    check("load_pix_count", pix_count, 0);
    stream(N, 1'b0, 1'b0, 1'b1);
    check("gapless_drop_err", drop_err, 0);
    read_cols(5, 1);
    read_cols(0, 1);
    read_cols(39, 1);
    read_reject(40, "rd_col40_rejected");
    check("rd_data_hold", rd_data, col_of(39));

    // Extra byte in FULL, then a pixel in IDLE
    pix_in = 8'hFF; pix_valid = 1'b1;
    cyc(1);
    pix_valid = 1'b0;
    check("drop_full", drop_err, 1);
    check("count_held_full", pix_count, N);
    read_cols(0, 2);
    release_win = 1'b1;
    cyc(1);
    release_win = 1'b0;
    check("release_win_ready", win_ready, 0);
    pix_in = 8'h77; pix_valid = 1'b1;
    cyc(1);
    pix_valid = 1'b0;
    check("drop_idle", drop_err, 1);
    do_start();
    check("drop_cleared", drop_err, 0);

    // Partial load, read attempt in LOAD, restart with a pixel presented
    stream(300, 1'b0, 1'b0, 1'b0);
    check("partial_count", pix_count, 300);
    read_reject(3, "rd_in_load");
    start = 1'b1; pix_valid = 1'b1; pix_in = 8'h11;
    cyc(1);
    start = 1'b0; pix_valid = 1'b0;
    check("restart_count", pix_count, 0);
    stream(N, 1'b1, 1'b0, 1'b1);
    read_cols(0, C);

    // start together with release_win in FULL goes to LOAD
    start = 1'b1; release_win = 1'b1;
    cyc(1);
    start = 1'b0; release_win = 1'b0;
    check("start_rel_pix_ready", pix_ready, 1);
    check("start_rel_win_ready", win_ready, 0);
    stream(N, 1'b0, 1'b1, 1'b1);
    check("gapped_drop_err", drop_err, 0);
    read_cols(5, 1);
    read_cols(17, 3);
    read_cols(39, 1);

    // Read accepted in the same cycle as release_win
    rd_en = 1'b1; rd_col = 6'd3; release_win = 1'b1;
    exp_q.push_back(col_of(3));
    cyc(1);
    rd_en = 1'b0; release_win = 1'b0;
    check("rd_with_release_valid", rd_valid, 1);
    check("rd_with_release_win", win_ready, 0);
    cyc(1);

    // Asynchronous reset in the middle of a load
    do_start();
    stream(100, 1'b1, 1'b0, 1'b0);
    check("pre_reset_count", pix_count, 100);
    #2 rst = 1'b1;
    #1;
    check("arst_pix_ready", pix_ready, 0);
    check("arst_win_ready", win_ready, 0);
    check("arst_rd_valid", rd_valid, 0);
    check("arst_rd_data", rd_data, 0);
    check("arst_pix_count", pix_count, 0);
    check("arst_drop_err", drop_err, 0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("idle_after_reset", pix_ready, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
